// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter types and helpers.
// FSM state enum, index-width helper, one-hot to binary.
package arb_pkg;

  typedef enum logic {
    ARB_EMPTY,
    ARB_FULL
  } arb_state_t;

  localparam int ARB_MAX_W = 32;

  // ceil(log2(n)), never below 1 so a
  // single requester still gets a 1-bit index
  function automatic int clog2m1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int unsigned oht2bin(
    input logic [ARB_MAX_W-1:0] oht
  );
    int unsigned b;
    b = 0;
    for (int i = 0; i < ARB_MAX_W; i++)
      if (oht[i]) b = b | i;
    return b;
  endfunction

endpackage

// File: rtl/arb_rr_sel.sv
// arb_rr_sel: round-robin one-hot select.
// in: req_vld, ptr; out: sel (one-hot or zero)
module arb_rr_sel
  import arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = clog2m1(WIDTH)
)(
  input  logic [WIDTH-1:0] req_vld,
  input  logic [IDX_W-1:0] ptr,
  output logic [WIDTH-1:0] sel
);

  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] msk_oh;
  logic [WIDTH-1:0] vld_oh;

  // only requesters above the last winner
  always_comb begin
    msk = '0;
    for (int i = 0; i < WIDTH; i++)
      msk[i] = req_vld[i] & (i > int'(ptr));
  end

  // x & -x isolates the lowest set bit
  assign msk_oh = msk & (~msk + WIDTH'(1));
  assign vld_oh = req_vld & (~req_vld + WIDTH'(1));

  assign sel = (|msk) ? msk_oh : vld_oh;

endmodule

// File: rtl/arb_rr_reg.sv
// arb_rr_reg: round-robin arbiter, registered output.
// req_vld/req_dat/req_rdy in; out_vld/out_rdy/out_dat/
// out_oht/out_idx out. ARB_RR_LOCK_EN adds req_lck.
module arb_rr_reg
  import arb_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DAT_W = 8,
  localparam int IDX_W = clog2m1(WIDTH)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   req_vld,
  input  logic [WIDTH*DAT_W-1:0] req_dat,
`ifdef ARB_RR_LOCK_EN
  input  logic [WIDTH-1:0]   req_lck,
`endif
  output logic [WIDTH-1:0]   req_rdy,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [DAT_W-1:0]   out_dat,
  output logic [WIDTH-1:0]   out_oht,
  output logic [IDX_W-1:0]   out_idx
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [WIDTH-1:0] rr;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] win;
  logic             load;
  logic             hs;
  logic [DAT_W-1:0] win_dat;
  logic [IDX_W-1:0] win_idx;

  arb_rr_sel #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_vld (req_vld),
    .ptr     (ptr),
    .sel     (rr)
  );

`ifdef ARB_RR_LOCK_EN
  logic             lck;
  logic [WIDTH-1:0] lck_oht;

  // a locked packet owns the channel until
  // its last beat, even across idle cycles
  assign sel = lck ? lck_oht : rr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lck     <= 1'b0;
      lck_oht <= '0;
    end else if (hs) begin
      lck     <= |(win & req_lck);
      lck_oht <= win;
    end
  end
`else
  assign sel = rr;
`endif

  assign out_vld = (state == ARB_FULL);
  assign load    = (state == ARB_EMPTY) | out_rdy;
  assign req_rdy = load ? sel : '0;
  assign win     = req_vld & req_rdy;
  assign hs      = |win;
  assign win_idx = IDX_W'(oht2bin(ARB_MAX_W'(win)));

  always_comb begin
    win_dat = '0;
    for (int i = 0; i < WIDTH; i++)
      if (win[i])
        win_dat = win_dat | req_dat[i*DAT_W +: DAT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_EMPTY;
      ptr     <= IDX_W'(WIDTH - 1);
      out_dat <= '0;
      out_oht <= '0;
      out_idx <= '0;
    end else if (load) begin
      if (hs) begin
        state   <= ARB_FULL;
        ptr     <= win_idx;
        out_dat <= win_dat;
        out_oht <= win;
        out_idx <= win_idx;
      end else begin
        state   <= ARB_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_arb_rr_reg.sv
// tb_arb_rr_reg: self-checking bench for arb_rr_reg.
// Scoreboard of expected beats plus directed scenarios.
module tb_arb_rr_reg;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [W-1:0]  oht;
    logic [IW-1:0] idx;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    req_vld;
  logic [W*DW-1:0] req_dat;
  logic [W-1:0]    req_lck;
  logic [W-1:0]    req_rdy;
  logic            out_vld;
  logic            out_rdy;
  logic [DW-1:0]   out_dat;
  logic [W-1:0]    out_oht;
  logic [IW-1:0]   out_idx;

  int pass  = 0;
  int total = 0;

  beat_t q[$];
  logic  m_full;
  int    m_ptr;
  logic  m_lck;
  int    m_lidx;

  always #5 clk = ~clk;

  arb_rr_reg #(
    .WIDTH (W),
    .DAT_W (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_dat (req_dat),
`ifdef ARB_RR_LOCK_EN
    .req_lck (req_lck),
`endif
    .req_rdy (req_rdy),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_dat (out_dat),
    .out_oht (out_oht),
    .out_idx (out_idx)
  );

  function automatic logic [W-1:0] m_sel();
    if (m_lck) return W'(1) << m_lidx;
    for (int i = m_ptr + 1; i < W; i++)
      if (req_vld[i]) return W'(1) << i;
    for (int i = 0; i < W; i++)
      if (req_vld[i]) return W'(1) << i;
    return '0;
  endfunction

  task automatic m_reset();
    q.delete();
    m_full = 1'b0;
    m_ptr  = W - 1;
    m_lck  = 1'b0;
    m_lidx = 0;
  endtask

  // one clock: model predicts req_rdy and the
  // next beat, DUT output is checked at negedge
  task automatic step();
    logic [W-1:0] s;
    logic [W-1:0] er;
    logic ld;
    logic drain;
    int wi;
    beat_t b;
    #1;
    ld = !m_full || out_rdy;
    drain = m_full && out_rdy;
    s = m_sel();
    er = ld ? s : '0;
    wi = -1;
    for (int i = 0; i < W; i++)
      if (er[i] && req_vld[i]) wi = i;
    total++;
    if (req_rdy !== er)
      $display("FAIL req_rdy: got %b want %b",
               req_rdy, er);
    else pass++;
    if (wi >= 0) begin
      b.dat = req_dat[wi*DW +: DW];
      b.oht = W'(1) << wi;
      b.idx = IW'(wi);
    end
    @(posedge clk);
    if (drain && q.size() > 0) void'(q.pop_front());
    if (ld) begin
      if (wi >= 0) begin
        q.push_back(b);
        m_full = 1'b1;
        m_ptr  = wi;
        m_lck  = req_lck[wi];
        m_lidx = wi;
      end else begin
        m_full = 1'b0;
      end
    end
`ifndef ARB_RR_LOCK_EN
    m_lck = 1'b0;
`endif
    @(negedge clk);
    total++;
    if (out_vld !== m_full)
      $display("FAIL out_vld: got %b want %b",
               out_vld, m_full);
    else pass++;
    if (m_full && q.size() > 0) begin
      total++;
      if ({out_dat, out_oht, out_idx} !== q[0])
        $display("FAIL sb_beat: got %h/%b/%0d want %h/%b/%0d",
                 out_dat, out_oht, out_idx,
                 q[0].dat, q[0].oht, q[0].idx);
      else pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_vld = '0;
    req_lck = '0;
    out_rdy = 1'b0;
    req_dat = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({out_vld, out_dat, out_oht, out_idx} !== '0)
      $display("FAIL reset_out: got %b/%h/%b/%0d want 0",
               out_vld, out_dat, out_oht, out_idx);
    else pass++;
    total++;
    if (req_rdy !== '0)
      $display("FAIL reset_rdy: got %b want 0000", req_rdy);
    else pass++;
    rst = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  task automatic test_rr();
    req_vld = 4'b1111;
    out_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (out_idx !== IW'(k % W) || out_vld !== 1'b1)
        $display("FAIL rr_seq%0d: got %0d/%b want %0d/1",
                 k, out_idx, out_vld, k % W);
      else pass++;
    end
  endtask

  task automatic test_wrap();
    logic [IW-1:0] exp_i [3];
    exp_i = '{2'd2, 2'd0, 2'd2};
    req_vld = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (out_idx !== exp_i[k])
        $display("FAIL wrap%0d: got %0d want %0d",
                 k, out_idx, exp_i[k]);
      else pass++;
    end
  endtask

  task automatic test_stall();
    req_vld = 4'b1000;
    req_dat[31:24] = 8'hA5;
    step();
    total++;
    if (out_idx !== 2'd3)
      $display("FAIL stall_load: got %0d want 3", out_idx);
    else pass++;
    out_rdy = 1'b0;
    req_vld = 4'b1111;
    repeat (5) begin
      #1;
      total++;
      if (req_rdy !== 4'b0000)
        $display("FAIL stall_rdy: got %b want 0000", req_rdy);
      else pass++;
      step();
      total++;
      if (out_dat !== 8'hA5 || out_oht !== 4'b1000)
        $display("FAIL stall_hold: got %h/%b want a5/1000",
                 out_dat, out_oht);
      else pass++;
    end
    out_rdy = 1'b1;
    #1;
    total++;
    if (req_rdy !== 4'b0001)
      $display("FAIL stall_release: got %b want 0001", req_rdy);
    else pass++;
    step();
    total++;
    if (out_idx !== 2'd0 || out_dat !== 8'h10)
      $display("FAIL stall_next: got %0d/%h want 0/10",
               out_idx, out_dat);
    else pass++;
  endtask

  task automatic test_drain();
    req_vld = '0;
    #1;
    total++;
    if (req_rdy !== 4'b0000)
      $display("FAIL drain_rdy: got %b want 0000", req_rdy);
    else pass++;
    step();
    total++;
    if (out_vld !== 1'b0 || out_dat !== 8'h10 ||
        out_oht !== 4'b0001)
      $display("FAIL drain: got %b/%h/%b want 0/10/0001",
               out_vld, out_dat, out_oht);
    else pass++;
  endtask

  task automatic test_mid_reset();
    req_vld = 4'b0001;
    req_dat[7:0] = 8'h3C;
    step();
    total++;
    if (out_vld !== 1'b1 || out_dat !== 8'h3C)
      $display("FAIL mrst_load: got %b/%h want 1/3c",
               out_vld, out_dat);
    else pass++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_vld !== 1'b0 || out_dat !== 8'h00)
      $display("FAIL mrst_async: got %b/%h want 0/00",
               out_vld, out_dat);
    else pass++;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    req_dat[7:0] = 8'h10;
    req_vld = 4'b0110;
    #1;
    total++;
    if (req_rdy !== 4'b0010)
      $display("FAIL mrst_rdy: got %b want 0010", req_rdy);
    else pass++;
    step();
    total++;
    if (out_idx !== 2'd1 || out_dat !== 8'h11)
      $display("FAIL mrst_grant: got %0d/%h want 1/11",
               out_idx, out_dat);
    else pass++;
  endtask

`ifdef ARB_RR_LOCK_EN
  task automatic test_lock();
    logic [W-1:0]  lk [6];
    logic [IW-1:0] ei [6];
    lk = '{4'b0000, 4'b0000, 4'b0100,
           4'b0100, 4'b0000, 4'b0000};
    ei = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    req_vld = 4'b1111;
    out_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_lck = lk[k];
      step();
      total++;
      if (out_idx !== ei[k])
        $display("FAIL lock%0d: got %0d want %0d",
                 k, out_idx, ei[k]);
      else pass++;
    end
    req_lck = '0;
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      req_vld = W'($urandom);
      req_dat = $urandom;
      out_rdy = ($urandom_range(0, 3) != 0);
`ifdef ARB_RR_LOCK_EN
      req_lck = ($urandom_range(0, 2) == 0) ?
                W'($urandom) : '0;
`endif
      step();
    end
    req_lck = '0;
  endtask

  initial begin
    test_reset();
    test_rr();
    test_wrap();
    test_stall();
    test_drain();
    test_mid_reset();
`ifdef ARB_RR_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
